// File: rtl/pipe_stall_sched.sv
// Stall scheduler for the pipeline clock-enable gater: merges hazard, multi-cycle and memory stalls.
// Optional stall performance counter is built when STALL_PERF_CNT_EN is defined.
module pipe_stall_sched #(
  parameter int MC_W   = 4,
  parameter int HZ_CYC = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_req,
  input  logic             mc_start,
  input  logic [MC_W-1:0]  mc_len,
  input  logic             mem_wait,
  input  logic             halt_req,
  output logic             stallb_en,
  output logic             ps_clk_stall,
  output logic [1:0]       stall_src,
  output logic             mc_pend,
  output logic             mc_ovf,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int HC_W = (HZ_CYC > 1) ? $clog2(HZ_CYC) : 1;
  localparam logic [HC_W-1:0] HZ_LOAD = HC_W'(HZ_CYC - 1);

  typedef enum logic [1:0] {RUN = 2'd0, HAZ = 2'd1, MC = 2'd2, MEMW = 2'd3} state_t;

  state_t          state_q, state_n;
  logic [MC_W-1:0] cnt_q, cnt_n;
  logic [MC_W-1:0] q_len_q, q_len_n;
  logic [HC_W-1:0] hcnt_q, hcnt_n;
  logic            pend_n, ovf_n;
  logic            stallb_d;
  logic [1:0]      src_d;
  logic            new_req, take, consume;

  assign new_req = mc_start && (mc_len != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      stallb_en <= 1'b1;
      stall_src <= 2'd0;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      mc_pend   <= 1'b0;
      mc_ovf    <= 1'b0;
    end else begin
      state_q   <= state_n;
      stallb_en <= stallb_d;
      stall_src <= src_d;
      cnt_q     <= cnt_n;
      hcnt_q    <= hcnt_n;
      mc_pend   <= pend_n;
      mc_ovf    <= ovf_n;
    end
  end

  // Queued length is qualified by mc_pend, so it needs no reset.
  always_ff @(posedge clk) begin
    q_len_q <= q_len_n;
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    hcnt_n  = hcnt_q;
    take    = 1'b0;
    consume = 1'b0;
    case (state_q)
      RUN, MEMW: begin
        if (mem_wait) begin
          state_n = MEMW;
        end else if (mc_pend) begin
          state_n = MC;
          cnt_n   = q_len_q - MC_W'(1);
          consume = 1'b1;
        end else if (new_req) begin
          state_n = MC;
          cnt_n   = mc_len - MC_W'(1);
          take    = 1'b1;
        end else if (hz_req) begin
          state_n = HAZ;
          hcnt_n  = HZ_LOAD;
        end else begin
          state_n = RUN;
        end
      end
      HAZ: begin
        if (mem_wait)             state_n = MEMW;
        else if (hcnt_q == '0)    state_n = RUN;
        else                      hcnt_n  = hcnt_q - HC_W'(1);
      end
      MC: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - MC_W'(1);
        end else if (mem_wait) begin
          state_n = MEMW;
        end else if (mc_pend) begin
          state_n = MC;
          cnt_n   = q_len_q - MC_W'(1);
          consume = 1'b1;
        end else begin
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // One-deep queue: a consumed slot is refilled by a same-cycle request.
  always_comb begin
    pend_n  = mc_pend;
    q_len_n = q_len_q;
    ovf_n   = mc_ovf;
    if (consume) begin
      pend_n = new_req;
      if (new_req) q_len_n = mc_len;
    end else if (new_req && !take) begin
      if (mc_pend) begin
        ovf_n = 1'b1;
      end else begin
        pend_n  = 1'b1;
        q_len_n = mc_len;
      end
    end
  end

  always_comb begin
    stallb_d = (state_n == RUN);
    src_d    = state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ps_clk_stall <= 1'b1;
    else      ps_clk_stall <= ~halt_req;
  end

`ifdef STALL_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            perf_q <= '0;
    else if (!stallb_en) perf_q <= sat_inc(perf_q);
  end

  assign stall_cnt = perf_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
